// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC^GHR-indexed 2-bit counter table with a reset
// sweep, single-cycle read-modify-write training and a saturating mispredict count.

module gshare_dp_array #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 2
) (
   input  logic          iClk,
   input  logic          iWe,
   input  logic [AW-1:0] iWAddr,
   input  logic [DW-1:0] iWData,
   output logic [DW-1:0] oWRdData,
   input  logic [AW-1:0] iRAddr,
   output logic [DW-1:0] oRData
);
   logic [DW-1:0] mem_q [DEPTH];

   assign oWRdData = mem_q[iWAddr];
   assign oRData   = mem_q[iRAddr];

   always_ff @(posedge iClk) begin
      if (iWe) mem_q[iWAddr] <= iWData;
   end
endmodule

module gshare_predictor #(
   parameter  int ENTRIES = 32,
   parameter  int GHR_W   = 5,
   parameter  int PC_W    = 16,
   parameter  int CNT_W   = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic [PC_W-1:0]  iFetchPc,
   input  logic             iFetchValid,
   output logic             oPredTaken,
   output logic [IDX_W-1:0] oPredIndex,
   output logic             oReady,
   input  logic             iUpdValid,
   input  logic [IDX_W-1:0] iUpdIndex,
   input  logic             iUpdTaken,
   input  logic             iUpdMispredict,
   output logic [CNT_W-1:0] oMispredCount
);
   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic [GHR_W:0]   ghr_ext;
   logic             run, we;
   logic [IDX_W-1:0] waddr;
   logic [1:0]       wdata, wr_back, rd_cnt;
   logic             unused_pc;

   assign unused_pc = ^{iFetchPc[PC_W-1:IDX_W+1], iFetchPc[0]};

   assign run           = (state_q == ST_RUN);
   assign oReady        = run;
   assign oPredIndex    = iFetchPc[IDX_W:1] ^ IDX_W'(ghr_q);
   assign oPredTaken    = run && iFetchValid && rd_cnt[1];
   assign oMispredCount = mcnt_q;

   // The sweep owns the write port during INIT; afterwards training does.
   assign we    = run ? iUpdValid : 1'b1;
   assign waddr = run ? iUpdIndex : sweep_q;

   always_comb begin
      wdata = 2'b01;
      if (run) begin
         if (iUpdTaken) wdata = (wr_back == 2'b11) ? 2'b11 : wr_back + 2'b01;
         else           wdata = (wr_back == 2'b00) ? 2'b00 : wr_back - 2'b01;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      ghr_d   = ghr_q;
      mcnt_d  = mcnt_q;
      ghr_ext = {ghr_q, iUpdTaken};
      if (!run) begin
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
      end else if (iUpdValid) begin
         ghr_d = ghr_ext[GHR_W-1:0];
         if (iUpdMispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
         ghr_q   <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         ghr_q   <= ghr_d;
         mcnt_q  <= mcnt_d;
      end
   end

   gshare_dp_array #(.DEPTH(ENTRIES), .AW(IDX_W), .DW(2)) u_tbl (
      .iClk     (iClk),
      .iWe      (we),
      .iWAddr   (waddr),
      .iWData   (wdata),
      .oWRdData (wr_back),
      .iRAddr   (oPredIndex),
      .oRData   (rd_cnt)
   );
endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboarded random + directed bench for gshare_predictor against a
// counter-table reference model.

module tb_gshare_predictor;
   localparam int ENTRIES = 32;
   localparam int IDX_W   = 5;
   localparam int GHR_W   = 5;
   localparam int PC_W    = 16;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             iRstN = 1'b0;
   logic [PC_W-1:0]  iFetchPc = '0;
   logic             iFetchValid = 1'b0;
   logic             oPredTaken;
   logic [IDX_W-1:0] oPredIndex;
   logic             oReady;
   logic             iUpdValid = 1'b0;
   logic [IDX_W-1:0] iUpdIndex = '0;
   logic             iUpdTaken = 1'b0;
   logic             iUpdMispredict = 1'b0;
   logic [CNT_W-1:0] oMispredCount;

   gshare_predictor #(.ENTRIES(ENTRIES), .GHR_W(GHR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .iClk(clk), .iRstN(iRstN), .iFetchPc(iFetchPc), .iFetchValid(iFetchValid),
      .oPredTaken(oPredTaken), .oPredIndex(oPredIndex), .oReady(oReady),
      .iUpdValid(iUpdValid), .iUpdIndex(iUpdIndex), .iUpdTaken(iUpdTaken),
      .iUpdMispredict(iUpdMispredict), .oMispredCount(oMispredCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ready;
      int pred;
      int idx;
      int cnt;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   total = 0;
   int   bad = 0;

   // Reference model: counters as plain integers 0..3, history as an integer.
   int m_cnt[ENTRIES];
   int m_ghr, m_mc, m_init_left;

   function automatic void chk(string name, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endfunction

   function automatic int pc_for(int idx);
      return ((((idx ^ m_ghr) & (ENTRIES - 1)) << 1) | int'($urandom_range(0, 1))
              | (int'($urandom) & 'hFFC0));
   endfunction

   function automatic void model_reset();
      m_init_left = ENTRIES;
      m_ghr = 0;
      m_mc = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input bit fv, input int pc, input bit uv, input int ui,
                        input bit ut, input bit um);
      exp_t e;
      int idx;
      iFetchValid = fv;
      iFetchPc = pc[PC_W-1:0];
      iUpdValid = uv;
      iUpdIndex = ui[IDX_W-1:0];
      iUpdTaken = ut;
      iUpdMispredict = um;
      #1;
      idx = ((pc >> 1) & (ENTRIES - 1)) ^ m_ghr;
      e.ready = (m_init_left == 0) ? 1 : 0;
      e.pred = (e.ready == 1 && fv && m_cnt[idx] >= 2) ? 1 : 0;
      e.idx = idx;
      e.cnt = m_mc;
      q.push_back(e);
      -> sample_ev;
      if (m_init_left > 0) begin
         m_init_left--;
         if (m_init_left == 0) foreach (m_cnt[i]) m_cnt[i] = 1;
      end else if (uv) begin
         int u;
         u = ui & (ENTRIES - 1);
         m_cnt[u] = ut ? ((m_cnt[u] == 3) ? 3 : m_cnt[u] + 1)
                       : ((m_cnt[u] == 0) ? 0 : m_cnt[u] - 1);
         m_ghr = ((m_ghr << 1) | int'(ut)) & ((1 << GHR_W) - 1);
         if (um && m_mc < (1 << CNT_W) - 1) m_mc++;
      end
      @(negedge clk);
   endtask

   task automatic upd(input int ui, input bit ut, input bit um);
      cycle(1'b1, pc_for(ui), 1'b1, ui, ut, um);
   endtask

   task automatic rand_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         int pc, fidx, ui;
         pc = int'($urandom) & 'hFFFF;
         fidx = ((pc >> 1) & (ENTRIES - 1)) ^ m_ghr;
         ui = ($urandom_range(0, 2) == 0) ? fidx : int'($urandom_range(0, 7));
         cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, ui,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      end
   endtask

   task automatic async_reset();
      #3;
      iRstN = 1'b0;
      #1;
      chk("rst_ready", oReady, 0);
      chk("rst_mcnt", oMispredCount, 0);
      chk("rst_pred", oPredTaken, 0);
      model_reset();
      @(negedge clk);
      iRstN = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         exp_t e;
         @(sample_ev);
         #1;
         if (q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = q.pop_front();
            chk("ready", oReady, e.ready);
            chk("pred", oPredTaken, e.pred);
            chk("idx", oPredIndex, e.idx);
            chk("mcnt", oMispredCount, e.cnt);
         end
      end
   end

   initial begin : stim
      model_reset();
      repeat (2) @(negedge clk);
      iRstN = 1'b1;
      // INIT window: fetch at PC 0, training attempts must be ignored.
      for (int k = 0; k < ENTRIES + 1; k++)
         cycle(1'b1, 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), 1'b1, 1'b1);
      // History hashing from GHR=0: T,T,N at idx 0 then fetch PC 0x0010.
      cycle(1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
      cycle(1'b1, 'h0010, 1'b0, 0, 1'b0, 1'b0);
      chk("ghr_after_ttn", m_ghr, 6);
      // Same-cycle fetch/update collision at idx 7, then re-fetch idx 7.
      upd(7, 1'b1, 1'b0);
      cycle(1'b1, pc_for(7), 1'b0, 0, 1'b0, 1'b0);
      // Idx 5: two taken, one not-taken.
      upd(5, 1'b1, 1'b0);
      upd(5, 1'b1, 1'b0);
      cycle(1'b1, pc_for(5), 1'b0, 0, 1'b0, 1'b0);
      upd(5, 1'b0, 1'b0);
      cycle(1'b1, pc_for(5), 1'b0, 0, 1'b0, 1'b0);
      // Saturation at idx 3: 4 taken, 5 not-taken.
      for (int k = 0; k < 4; k++) upd(3, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) upd(3, 1'b0, 1'b0);
      cycle(1'b1, pc_for(3), 1'b0, 0, 1'b0, 1'b0);
      // Mispredict count: 3, then enough more to hit saturation.
      for (int k = 0; k < 3; k++) cycle(1'b0, 0, 1'b1, 9, 1'b0, 1'b1);
      cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) cycle(1'b0, 0, 1'b1, 10, k[0], 1'b1);
      cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      rand_cycles(1200);
      async_reset();
      for (int k = 0; k < ENTRIES; k++) cycle(1'b1, pc_for(k), 1'b0, 0, 1'b0, 1'b0);
      // Every entry must be back to weak not-taken after the sweep.
      for (int i = 0; i < ENTRIES; i++) begin
         upd(i, 1'b1, 1'b0);
         cycle(1'b1, pc_for(i), 1'b0, 0, 1'b0, 1'b0);
      end
      rand_cycles(600);
      #5;
      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
